labeled_wr_queue: RTL
=====================

LABELED_WR_QUEUE -- requirements
Module: labeled_wr_queue

Interface
REQ-001 Parameter DATA_W, default 8: width of the data payload.
REQ-002 Parameter DEPTH, default 4: number of queue entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  {L}  write request present.
REQ-006 in_ready  output  1  {L}  queue accepts a request this cycle.
REQ-007 in_lbl  input  1  {L}  label of the request: 0 = L, 1 = H.
REQ-008 in_data  input  DATA_W  {LH in_lbl}  request payload.
REQ-009 out_stall  input  1  {L}  downstream cannot take a write this cycle.
REQ-010 out_w_en  output  1  {L}  write strobe to the downstream label-change register.
REQ-011 out_lbl  output  1  {L}  label of the head entry.
REQ-012 out_data  output  DATA_W  {LH out_lbl}  payload of the head entry.
REQ-013 count  output  log2(DEPTH)+1  {L}  number of occupied entries.

Function
REQ-014 Enqueue occurs when in_valid && in_ready; entry {in_lbl, in_data} is written at the tail, and the tail pointer advances modulo DEPTH.
REQ-015 in_ready SHALL be driven from registered state only: it is 1 iff count < DEPTH and rst is 0.
REQ-016 out_w_en = (count != 0) && !out_stall && !rst; when it is 1, the head entry pops and the head pointer advances modulo DEPTH.
REQ-017 out_lbl and out_data SHALL show the head entry whenever count != 0, and SHALL be 0 and 0 whenever count == 0.
REQ-018 No bypass path: minimum latency from an accepted enqueue to out_w_en is 1 cycle.
REQ-019 Entries leave strictly in FIFO order; an entry's label is fixed at enqueue and is never altered while queued.
REQ-020 A popped entry's label and data SHALL be scrubbed to 0 in the same clock edge as the pop, so no H residue remains in vacated slots.
REQ-021 Simultaneous enqueue and pop with 0 < count < DEPTH: both occur, and count is unchanged.
REQ-022 Full (count == DEPTH): in_ready = 0, and in_valid is ignored even if a pop occurs in the same cycle.
REQ-023 Empty (count == 0): out_w_en = 0 regardless of out_stall, and an enqueue makes count = 1 on the next cycle.
REQ-024 When out_stall is 1, the head entry and out_lbl/out_data are held stable and count does not decrease.
REQ-025 Occupancy states EMPTY, PARTIAL and FULL are derived from count: EMPTY->PARTIAL on enqueue only; PARTIAL->FULL on enqueue without pop at count == DEPTH-1; FULL->PARTIAL on pop; PARTIAL->EMPTY on pop without enqueue at count == 1.
REQ-026 All control state (pointers, count, strobes) SHALL be typed {L}; only entry data may carry a dependent label.

Reset
REQ-027 While rst is 1 at a clock edge, all of the following are cleared: pointers 0, count 0, every entry label 0 and data 0.
REQ-028 While rst is high: in_ready = 0, out_w_en = 0, out_lbl = 0, out_data = 0.
REQ-029 Reset mid-operation discards all queued entries, and no pop strobe is issued in that cycle.

Structure
REQ-030 Shared package labeled_q_pkg SHALL hold LBL_L = 0, LBL_H = 1, and default DATA_W/DEPTH constants.
REQ-031 One sub-module, labeled_slot, SHALL implement a single entry with write, scrub and reset; the top instantiates DEPTH of them plus pointer/count logic.

Verification
REQ-032 Reset, then idle: in_ready = 1, count = 0, out_w_en = 0, out_data = 0.
REQ-033 Enqueue (L,0x11), (H,0xA5), (L,0x22) with out_stall = 0: out_w_en pulses on 3 consecutive cycles starting 1 cycle later, with out_lbl 0,1,0 and out_data 0x11,0xA5,0x22.
REQ-034 Hold out_stall = 1 and enqueue 5 requests: count reaches 4, in_ready = 0 on the 5th request, and the 5th is dropped; release the stall and exactly 4 writes follow, in order.
REQ-035 Full queue, out_stall = 0, in_valid = 1 for one cycle: one pop occurs, no enqueue occurs, and count = 3.
REQ-036 Enqueue (H,0xFF), pop it, then inspect the vacated slot and outputs: label 0, data 0, out_data 0.
REQ-037 Assert rst with 3 entries queued and out_stall = 0: no out_w_en that cycle, and count = 0 on the next cycle.

Source files
------------

// File: rtl/labeled_q_pkg.sv
// Shared constants and occupancy typing for the labeled write queue.
// Label encoding: 0 = L (low), 1 = H (high).
package labeled_q_pkg;

    localparam logic LBL_L      = 1'b0;
    localparam logic LBL_H      = 1'b1;
    localparam int   DATA_W_DEF = 8;
    localparam int   DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    function automatic occ_e occ_of(input int cnt, input int depth);
        if (cnt == 0)
            return OCC_EMPTY;
        else if (cnt >= depth)
            return OCC_FULL;
        else
            return OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/labeled_slot.sv
// One queue entry: a label bit plus payload, written on enqueue and scrubbed
// back to L/0 when popped so no H residue is left behind.
module labeled_slot
    import labeled_q_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_lbl,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              scrub,
    output logic              lbl,
    output logic [DATA_W-1:0] data
);

    logic              lbl_q, lbl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A write and a scrub never target the same slot in one cycle; write wins anyway.
    always_comb begin
        lbl_d  = lbl_q;
        data_d = data_q;
        if (wr_en) begin
            lbl_d  = wr_lbl;
            data_d = wr_data;
        end else if (scrub) begin
            lbl_d  = LBL_L;
            data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lbl_q  <= LBL_L;
            data_q <= '0;
        end else begin
            lbl_q  <= lbl_d;
            data_q <= data_d;
        end
    end

    assign lbl  = lbl_q;
    assign data = data_q;

endmodule

// File: rtl/labeled_wr_queue.sv
// FIFO of labeled write requests feeding a downstream label-change register.
// Control state is label-free; only slot contents carry the request label.
module labeled_wr_queue
    import labeled_q_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_lbl,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     out_stall,
    output logic                     out_w_en,
    output logic                     out_lbl,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    occ_e          occ;
    logic          push;
    logic          pop;

    logic [DEPTH-1:0]  slot_lbl;
    logic [DATA_W-1:0] slot_data [DEPTH];

    // Handshakes depend only on registered occupancy (plus reset), never on in_valid.
    always_comb begin
        occ      = occ_of(int'(count_q), DEPTH);
        in_ready = !rst && (occ != OCC_FULL);
        out_w_en = !rst && (occ != OCC_EMPTY) && !out_stall;
        push     = in_valid && in_ready;
        pop      = out_w_en;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push)
            tail_d = tail_q + PW'(1);
        if (pop)
            head_d = head_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        out_lbl  = LBL_L;
        out_data = '0;
        if (!rst && (occ != OCC_EMPTY)) begin
            out_lbl  = slot_lbl[head_q];
            out_data = slot_data[head_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        labeled_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (push && (tail_q == PW'(i))),
            .wr_lbl  (in_lbl),
            .wr_data (in_data),
            .scrub   (pop && (head_q == PW'(i))),
            .lbl     (slot_lbl[i]),
            .data    (slot_data[i])
        );
    end

    assign count = count_q;

endmodule
